// File: rtl/acc_pkg.sv
// Shared encodings for the 16-bit accumulator machine: opcodes, mux/ALU/PC selects,
// control-state encoding and the opcode-to-execute-state decode.
package acc_pkg;

    localparam int OPW  = 4;
    localparam int SELW = 3;

    localparam logic [OPW-1:0] OP_ADD   = 4'h0;
    localparam logic [OPW-1:0] OP_SUB   = 4'h1;
    localparam logic [OPW-1:0] OP_AND   = 4'h2;
    localparam logic [OPW-1:0] OP_OR    = 4'h3;
    localparam logic [OPW-1:0] OP_LOAD  = 4'h4;
    localparam logic [OPW-1:0] OP_STORE = 4'h5;
    localparam logic [OPW-1:0] OP_LI    = 4'h6;
    localparam logic [OPW-1:0] OP_BEQZ  = 4'h7;
    localparam logic [OPW-1:0] OP_BNEZ  = 4'h8;
    localparam logic [OPW-1:0] OP_JUMP  = 4'h9;
    localparam logic [OPW-1:0] OP_HALT  = 4'hF;

    localparam logic [SELW-1:0] ACC_SRC_ALU  = 3'd0;
    localparam logic [SELW-1:0] ACC_SRC_MEM  = 3'd1;
    localparam logic [SELW-1:0] ACC_SRC_SEXT = 3'd2;
    localparam logic [SELW-1:0] ACC_SRC_ZEXT = 3'd3;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_INC = 3'd4;

    localparam logic [1:0] PC_SRC_INC    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // S_IRLD is the single cycle after a completed fetch that loads IR and bumps PC.
    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_IRLD   = 4'd2,
        S_DECODE = 4'd3,
        S_ALU    = 4'd4,
        S_MRD    = 4'd5,
        S_MWB    = 4'd6,
        S_MWR    = 4'd7,
        S_LI     = 4'd8,
        S_BR     = 4'd9,
        S_JMP    = 4'd10,
        S_HALT   = 4'd11
    } state_e;

    function automatic logic is_illegal_op(input logic [OPW-1:0] opcode);
        return (opcode >= 4'hA) && (opcode <= 4'hE);
    endfunction

    function automatic state_e decode_target(input logic [OPW-1:0] opcode);
        state_e target;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: target = S_ALU;
            OP_LOAD:                       target = S_MRD;
            OP_STORE:                      target = S_MWR;
            OP_LI:                         target = S_LI;
            OP_BEQZ, OP_BNEZ:              target = S_BR;
            OP_JUMP:                       target = S_JMP;
            OP_HALT:                       target = S_HALT;
            default:                       target = S_FETCH;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/acc_control_fsm.sv
// Multicycle control unit for the accumulator datapath: fetch/decode/execute sequencing,
// memory-ready stalls and registered control strobes decoded from the next state.
module acc_control_fsm
    import acc_pkg::*;
(
    input  logic            CLK,
    input  logic            Reset_n,
    input  logic [15:0]     Instr,
    input  logic            AccZero,
    input  logic            MemReady,
    output logic            PCWrite,
    output logic            IRWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IorD,
    output logic            AccWrite,
    output logic [SELW-1:0] AccSrc,
    output logic [2:0]      ALUOp,
    output logic [1:0]      PCSrc,
    output logic            Halted,
    output logic            Illegal
);

    state_e          state_q, state_d;
    logic            pc_write_q, pc_write_d;
    logic            ir_write_q, ir_write_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic            iord_q, iord_d;
    logic            acc_write_q, acc_write_d;
    logic [SELW-1:0] acc_src_q, acc_src_d;
    logic [2:0]      alu_op_q, alu_op_d;
    logic [1:0]      pc_src_q, pc_src_d;
    logic            halted_q, halted_d;
    logic            illegal_q, illegal_d;

    logic [OPW-1:0]  opcode;
    logic            branch_taken;
    logic            unused_instr_bits;

    assign opcode            = Instr[15:16-OPW];
    assign unused_instr_bits = ^Instr[15-OPW:0];
    assign branch_taken      = ((opcode == OP_BEQZ) &&  AccZero) ||
                               ((opcode == OP_BNEZ) && !AccZero);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  if (MemReady) state_d = S_IRLD;
            S_IRLD:   state_d = S_DECODE;
            S_DECODE: state_d = decode_target(opcode);
            S_MRD:    if (MemReady) state_d = S_MWB;
            S_MWR:    if (MemReady) state_d = S_FETCH;
            S_ALU, S_MWB, S_LI, S_BR, S_JMP: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    // Outputs are a function of the state being entered, so they line up with it once registered.
    always_comb begin
        pc_write_d  = 1'b0;
        ir_write_d  = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        iord_d      = 1'b0;
        acc_write_d = 1'b0;
        acc_src_d   = ACC_SRC_ALU;
        alu_op_d    = ALU_ADD;
        pc_src_d    = PC_SRC_INC;
        halted_d    = halted_q || (state_d == S_HALT);
        illegal_d   = illegal_q || ((state_q == S_DECODE) && is_illegal_op(opcode));
        case (state_d)
            S_FETCH: begin
                mem_read_d = 1'b1;
            end
            S_IRLD: begin
                ir_write_d = 1'b1;
                pc_write_d = 1'b1;
                alu_op_d   = ALU_INC;
                pc_src_d   = PC_SRC_INC;
            end
            S_ALU: begin
                acc_write_d = 1'b1;
                acc_src_d   = ACC_SRC_ALU;
                alu_op_d    = opcode[2:0];
            end
            S_MRD: begin
                mem_read_d = 1'b1;
                iord_d     = 1'b1;
            end
            S_MWB: begin
                acc_write_d = 1'b1;
                acc_src_d   = ACC_SRC_MEM;
            end
            S_MWR: begin
                mem_write_d = 1'b1;
                iord_d      = 1'b1;
            end
            S_LI: begin
                acc_write_d = 1'b1;
                acc_src_d   = ACC_SRC_SEXT;
            end
            S_BR: begin
                pc_write_d = branch_taken;
                pc_src_d   = PC_SRC_BRANCH;
            end
            S_JMP: begin
                pc_write_d = 1'b1;
                pc_src_d   = PC_SRC_JUMP;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_INIT;
            pc_write_q  <= 1'b0;
            ir_write_q  <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            iord_q      <= 1'b0;
            acc_write_q <= 1'b0;
            acc_src_q   <= '0;
            alu_op_q    <= '0;
            pc_src_q    <= '0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_write_q  <= pc_write_d;
            ir_write_q  <= ir_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            iord_q      <= iord_d;
            acc_write_q <= acc_write_d;
            acc_src_q   <= acc_src_d;
            alu_op_q    <= alu_op_d;
            pc_src_q    <= pc_src_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    assign PCWrite  = pc_write_q;
    assign IRWrite  = ir_write_q;
    assign MemRead  = mem_read_q;
    assign MemWrite = mem_write_q;
    assign IorD     = iord_q;
    assign AccWrite = acc_write_q;
    assign AccSrc   = acc_src_q;
    assign ALUOp    = alu_op_q;
    assign PCSrc    = pc_src_q;
    assign Halted   = halted_q;
    assign Illegal  = illegal_q;

endmodule

// File: tb/tb_acc_control_fsm.sv
// Directed bench for acc_control_fsm: every cycle's packed control word is compared
// against hand-built expectations.
module tb_acc_control_fsm;

    logic        CLK;
    logic        Reset_n;
    logic [15:0] Instr;
    logic        AccZero;
    logic        MemReady;
    logic        PCWrite, IRWrite, MemRead, MemWrite, IorD, AccWrite;
    logic [2:0]  AccSrc;
    logic [2:0]  ALUOp;
    logic [1:0]  PCSrc;
    logic        Halted, Illegal;

    logic [15:0] observed;
    int          checks;
    int          failures;
    logic        expIll;

    logic [15:0] tInstr [11];
    logic        tZero  [11];
    logic [15:0] tExp   [11];

    acc_control_fsm dut (
        .CLK      (CLK),
        .Reset_n  (Reset_n),
        .Instr    (Instr),
        .AccZero  (AccZero),
        .MemReady (MemReady),
        .PCWrite  (PCWrite),
        .IRWrite  (IRWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .IorD     (IorD),
        .AccWrite (AccWrite),
        .AccSrc   (AccSrc),
        .ALUOp    (ALUOp),
        .PCSrc    (PCSrc),
        .Halted   (Halted),
        .Illegal  (Illegal)
    );

    assign observed = {PCWrite, IRWrite, MemRead, MemWrite, IorD, AccWrite,
                       AccSrc, ALUOp, PCSrc, Halted, Illegal};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [15:0] pack(input logic pcw, input logic irw, input logic mr,
                                         input logic mw, input logic iord, input logic accw,
                                         input logic [2:0] src, input logic [2:0] op,
                                         input logic [1:0] pcs, input logic h, input logic il);
        return {pcw, irw, mr, mw, iord, accw, src, op, pcs, h, il};
    endfunction

    task automatic stepCycle;
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] instr, input logic ready, input logic zero);
        Instr    = instr;
        MemReady = ready;
        AccZero  = zero;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    // Starts in a FETCH cycle; leaves the bench at the first cycle of the execute state.
    task automatic fetchDecode(input string tag, input logic [15:0] instr, input logic zero);
        applyStimulus(instr, 1'b1, zero);
        checkOutput({tag, "_fetch"}, observed, pack(0,0,1,0,0,0,3'd0,3'd0,2'd0,0,expIll));
        stepCycle;
        checkOutput({tag, "_irld"}, observed, pack(1,1,0,0,0,0,3'd0,3'd4,2'd0,0,expIll));
        stepCycle;
        checkOutput({tag, "_decode"}, observed, pack(0,0,0,0,0,0,3'd0,3'd0,2'd0,0,expIll));
        stepCycle;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        expIll   = 1'b0;
        Reset_n  = 1'b0;
        applyStimulus(16'h0000, 1'b0, 1'b0);

        tInstr[0]  = 16'h0005; tZero[0]  = 0; tExp[0]  = pack(0,0,0,0,0,1,3'd0,3'd0,2'd0,0,0);
        tInstr[1]  = 16'h1234; tZero[1]  = 0; tExp[1]  = pack(0,0,0,0,0,1,3'd0,3'd1,2'd0,0,0);
        tInstr[2]  = 16'h2000; tZero[2]  = 1; tExp[2]  = pack(0,0,0,0,0,1,3'd0,3'd2,2'd0,0,0);
        tInstr[3]  = 16'h3ABC; tZero[3]  = 0; tExp[3]  = pack(0,0,0,0,0,1,3'd0,3'd3,2'd0,0,0);
        tInstr[4]  = 16'h6FFF; tZero[4]  = 0; tExp[4]  = pack(0,0,0,0,0,1,3'd2,3'd0,2'd0,0,0);
        tInstr[5]  = 16'h9010; tZero[5]  = 0; tExp[5]  = pack(1,0,0,0,0,0,3'd0,3'd0,2'd2,0,0);
        tInstr[6]  = 16'h7003; tZero[6]  = 1; tExp[6]  = pack(1,0,0,0,0,0,3'd0,3'd0,2'd1,0,0);
        tInstr[7]  = 16'h7003; tZero[7]  = 0; tExp[7]  = pack(0,0,0,0,0,0,3'd0,3'd0,2'd1,0,0);
        tInstr[8]  = 16'h8003; tZero[8]  = 1; tExp[8]  = pack(0,0,0,0,0,0,3'd0,3'd0,2'd1,0,0);
        tInstr[9]  = 16'h8003; tZero[9]  = 0; tExp[9]  = pack(1,0,0,0,0,0,3'd0,3'd0,2'd1,0,0);
        tInstr[10] = 16'h5000; tZero[10] = 0; tExp[10] = pack(0,0,0,1,1,0,3'd0,3'd0,2'd0,0,0);

        // Reset held three cycles, then the single INIT cycle and a stalled fetch.
        repeat (3) stepCycle;
        checkOutput("reset_held", observed, 16'h0000);
        Reset_n = 1'b1;
        checkOutput("init_cycle", observed, 16'h0000);
        stepCycle;
        checkOutput("first_fetch", observed, pack(0,0,1,0,0,0,3'd0,3'd0,2'd0,0,0));
        stepCycle;
        checkOutput("fetch_stall", observed, pack(0,0,1,0,0,0,3'd0,3'd0,2'd0,0,0));

        // Single-cycle execute instructions with MemReady tied high.
        for (int i = 0; i < 11; i++) begin
            fetchDecode($sformatf("vec%0d", i), tInstr[i], tZero[i]);
            checkOutput($sformatf("vec%0d_exec", i), observed, tExp[i]);
            stepCycle;
        end

        // LOAD with three not-ready cycles in the memory read.
        fetchDecode("load", 16'h4010, 1'b0);
        MemReady = 1'b0;
        checkOutput("load_mrd0", observed, pack(0,0,1,0,1,0,3'd0,3'd0,2'd0,0,0));
        for (int i = 1; i < 4; i++) begin
            stepCycle;
            checkOutput($sformatf("load_mrd%0d", i), observed, pack(0,0,1,0,1,0,3'd0,3'd0,2'd0,0,0));
        end
        MemReady = 1'b1;
        stepCycle;
        checkOutput("load_mwb", observed, pack(0,0,0,0,0,1,3'd1,3'd0,2'd0,0,0));
        stepCycle;

        // Undefined opcode falls straight back to fetch with the sticky flag set.
        fetchDecode("illegal", 16'hB000, 1'b0);
        checkOutput("illegal_refetch", observed, pack(0,0,1,0,0,0,3'd0,3'd0,2'd0,0,1));
        expIll = 1'b1;

        // STORE stalled, then reset asserted between clock edges.
        fetchDecode("store", 16'h5123, 1'b0);
        MemReady = 1'b0;
        checkOutput("store_mwr", observed, pack(0,0,0,1,1,0,3'd0,3'd0,2'd0,0,1));
        stepCycle;
        checkOutput("store_stall", observed, pack(0,0,0,1,1,0,3'd0,3'd0,2'd0,0,1));
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("async_reset", observed, 16'h0000);
        expIll = 1'b0;
        stepCycle;
        Reset_n = 1'b1;
        checkOutput("restart_init", observed, 16'h0000);
        stepCycle;
        checkOutput("restart_fetch", observed, pack(0,0,1,0,0,0,3'd0,3'd0,2'd0,0,0));

        // HALT is absorbing whatever MemReady does.
        fetchDecode("halt", 16'hF000, 1'b0);
        checkOutput("halt_enter", observed, pack(0,0,0,0,0,0,3'd0,3'd0,2'd0,1,0));
        for (int i = 0; i < 20; i++) begin
            applyStimulus(16'h0000, i[0], 1'b0);
            stepCycle;
            checkOutput($sformatf("halt_hold%0d", i), observed, pack(0,0,0,0,0,0,3'd0,3'd0,2'd0,1,0));
        end
        Reset_n = 1'b0;
        #1;
        checkOutput("halt_reset", observed, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
